obi_outst_tracker: RTL and testbench
====================================

// Module: obi_outst_tracker
// PURPOSE
//  Parametrised multi-channel OBI outstanding-transaction tracker for the formal wrapper.
//  Counts granted-but-unanswered requests per channel and exposes grant/rvalid legality.
//  Detects protocol violations and response timeouts, latching each in sticky per-channel flags.
//  One instance replaces the ad-hoc instr/data counters; flags and legality outputs feed assume/assert properties.
// PARAMETERS
//  NUM_CH     2   number of independent bus channels (e.g. 0=instr, 1=data)
//  MAX_OUTST  2   max outstanding requests per channel (>=1)
//  CNT_W      $clog2(MAX_OUTST+1)   per-channel counter width (derived, do not override)
//  TIMEOUT    16  cycles waiting for rvalid before timeout flag; 0 disables watchdog
//  AW         32  address width (address tracking only)
// PORTS
//  clock                 in   1            clock, all state on rising edge
//  reset                 in   1            asynchronous, active-high reset
//  req_i                 in   NUM_CH       per-channel request
//  gnt_i                 in   NUM_CH       per-channel grant
//  rvalid_i              in   NUM_CH       per-channel response valid
//  addr_i                in   NUM_CH*AW    per-channel request address, ch k at [k*AW +: AW]
//  outst_o               out  NUM_CH*CNT_W current outstanding count, ch k at [k*CNT_W +: CNT_W]
//  gnt_allowed_o         out  NUM_CH       grant legal this cycle
//  rvalid_allowed_o      out  NUM_CH       rvalid legal this cycle
//  err_gnt_no_req_o      out  NUM_CH       sticky: gnt seen without req
//  err_rvalid_no_outst_o out  NUM_CH       sticky: rvalid seen with count 0
//  err_overflow_o        out  NUM_CH       sticky: accepted req would exceed MAX_OUTST
//  err_timeout_o         out  NUM_CH       sticky: rvalid wait reached TIMEOUT
//  any_err_o             out  1            OR of all sticky flags, all channels
//  resp_addr_o           out  NUM_CH*AW    address of oldest outstanding req per channel
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-transaction): all counts, wait counters, flags,
//    FIFO pointers -> 0. Outputs after reset: outst_o=0, rvalid_allowed_o=0, all err_*=0,
//    any_err_o=0, resp_addr_o=0, gnt_allowed_o=all 1s.
//  - Channels fully independent; no cross-channel interaction except any_err_o.
//  - acc=req_i&gnt_i. Count update per channel, next cycle:
//      cnt==0 & rvalid          : err_rvalid_no_outst set; rvalid ignored; count = acc ? 1 : 0
//      cnt==MAX & acc & !rvalid : err_overflow set; count holds MAX (saturate)
//      otherwise                : count = cnt + acc - rvalid (simultaneous acc+rvalid -> unchanged)
//  - gnt_i & !req_i: err_gnt_no_req set; no count change.
//  - gnt_allowed_o = (cnt < MAX_OUTST) | rvalid_i (combinational; response frees a slot same cycle).
//  - rvalid_allowed_o = (cnt != 0), combinational from registered count.
//  - Watchdog (TIMEOUT>0), per channel: wait counter clears when cnt==0 or rvalid_i;
//    else increments, saturating at TIMEOUT. err_timeout set on the clock edge where it
//    reaches TIMEOUT, i.e. the cycle after the TIMEOUT-th consecutive waiting cycle.
//    TIMEOUT=0: no watchdog logic, err_timeout_o tied 0.
//  - Sticky flags clear only on reset. All err_* are registered; any_err_o is OR of registers.
//  - Responses are in order per channel (OBI); no IDs.
// CONFIGURATION
//  OBI_TRACK_ADDR_EN defined: per-channel FIFO, depth MAX_OUTST, width AW.
//    - Push addr_i on acc, except in the overflow case.
//    - Pop on rvalid, except when cnt==0.
//    - Push+pop same cycle on a full FIFO is legal.
//    - Pointers wrap modulo MAX_OUTST.
//    - resp_addr_o = head entry when cnt!=0, else 0.
//  OBI_TRACK_ADDR_EN undefined: no FIFO storage; addr_i ignored; resp_addr_o tied 0.
//    Counting, legality and flag behaviour are identical with or without the macro.
// TESTING
//  T1 reset: reset=1 asynchronously -> outst_o=0, all err_*=0, gnt_allowed_o=2'b11, rvalid_allowed_o=0.
//  T2 fill/drain, MAX=2: ch0 acc cycles 1,2 -> outst=2, gnt_allowed[0]=0; rvalid cycle 3 -> outst=1.
//     acc+rvalid same cycle at outst=1 -> outst stays 1.
//  T3 violations: rvalid[1] at outst=0 -> err_rvalid_no_outst_o[1]=1, outst[1]=0, any_err_o=1,
//     flags persist 10 cycles. gnt[0] w/o req -> err_gnt_no_req_o[0]=1.
//  T4 overflow: ch0 at 2 outstanding, acc w/o rvalid -> err_overflow_o[0]=1, outst[0] stays 2.
//  T5 timeout, TIMEOUT=4: acc cycle 0, no rvalid -> err_timeout_o[0]=1 from cycle 5.
//     rvalid on cycle 3 instead -> flag stays 0.
//  T6 macro on: ch0 acc addr 0x100 then 0x200 -> resp_addr ch0 = 0x100 until first rvalid, then 0x200.
//     Assert reset mid-run -> resp_addr_o=0, outst_o=0 immediately.

Source files
------------

// File: rtl/obi_outst_tracker.sv
// Per-channel OBI outstanding-request tracker with sticky protocol/timeout flags.
// Define OBI_TRACK_ADDR_EN to keep an in-order address FIFO that drives resp_addr_o.
module obi_outst_tracker #(
  parameter int NUM_CH    = 2,
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1),
  parameter int TIMEOUT   = 16,
  parameter int AW        = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       req_i,
  input  logic [NUM_CH-1:0]       gnt_i,
  input  logic [NUM_CH-1:0]       rvalid_i,
  input  logic [NUM_CH*AW-1:0]    addr_i,
  output logic [NUM_CH*CNT_W-1:0] outst_o,
  output logic [NUM_CH-1:0]       gnt_allowed_o,
  output logic [NUM_CH-1:0]       rvalid_allowed_o,
  output logic [NUM_CH-1:0]       err_gnt_no_req_o,
  output logic [NUM_CH-1:0]       err_rvalid_no_outst_o,
  output logic [NUM_CH-1:0]       err_overflow_o,
  output logic [NUM_CH-1:0]       err_timeout_o,
  output logic                    any_err_o,
  output logic [NUM_CH*AW-1:0]    resp_addr_o
);

  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_OUTST);

`ifdef OBI_TRACK_ADDR_EN
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [PW-1:0] LAST = PW'(MAX_OUTST - 1);
`else
  logic unused_addr;
  assign unused_addr = ^addr_i;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic acc, rv, empty, full, ovf, push, pop;
    logic e_gnt, e_rv, e_ovf;

    assign acc   = req_i[k] & gnt_i[k];
    assign rv    = rvalid_i[k];
    assign empty = (cnt == '0);
    assign full  = (cnt == MAXC);
    assign ovf   = full & acc & ~rv;
    // A response with nothing outstanding is dropped; an overflowing
    // request is not accepted into the count.
    assign push  = acc & ~ovf;
    assign pop   = rv & ~empty;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt   <= '0;
        e_gnt <= 1'b0;
        e_rv  <= 1'b0;
        e_ovf <= 1'b0;
      end else begin
        cnt   <= cnt + CNT_W'(push) - CNT_W'(pop);
        e_gnt <= e_gnt | (gnt_i[k] & ~req_i[k]);
        e_rv  <= e_rv | (empty & rv);
        e_ovf <= e_ovf | ovf;
      end
    end

    assign outst_o[k*CNT_W +: CNT_W] = cnt;
    assign gnt_allowed_o[k]          = ~full | rv;
    assign rvalid_allowed_o[k]       = ~empty;
    assign err_gnt_no_req_o[k]       = e_gnt;
    assign err_rvalid_no_outst_o[k]  = e_rv;
    assign err_overflow_o[k]         = e_ovf;

    if (TIMEOUT > 0) begin : g_wd
      localparam int TW = $clog2(TIMEOUT + 1);
      localparam logic [TW-1:0] TO = TW'(TIMEOUT);
      logic [TW-1:0] wcnt;
      logic          e_to;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          wcnt <= '0;
          e_to <= 1'b0;
        end else if (empty | rv) begin
          wcnt <= '0;
        end else if (wcnt != TO) begin
          wcnt <= wcnt + TW'(1);
          if (wcnt == TO - TW'(1)) e_to <= 1'b1;
        end
      end

      assign err_timeout_o[k] = e_to;
    end else begin : g_nowd
      assign err_timeout_o[k] = 1'b0;
    end

`ifdef OBI_TRACK_ADDR_EN
    logic [AW-1:0] mem [MAX_OUTST];
    logic [PW-1:0] wp, rp;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push) wp <= (wp == LAST) ? '0 : wp + PW'(1);
        if (pop)  rp <= (rp == LAST) ? '0 : rp + PW'(1);
      end
    end

    // On a full FIFO wp==rp: the head is read combinationally before the
    // overwrite lands, so simultaneous push and pop is safe.
    always_ff @(posedge clock) begin
      if (push) mem[wp] <= addr_i[k*AW +: AW];
    end

    assign resp_addr_o[k*AW +: AW] = empty ? '0 : mem[rp];
`else
    assign resp_addr_o[k*AW +: AW] = '0;
`endif
  end

  assign any_err_o = |{err_gnt_no_req_o, err_rvalid_no_outst_o,
                       err_overflow_o, err_timeout_o};

endmodule

// File: tb/tb_obi_outst_tracker.sv
// Directed bench for obi_outst_tracker (2 channels, MAX_OUTST=2, TIMEOUT=4).
// Address expectations depend on whether OBI_TRACK_ADDR_EN is defined.
module tb_obi_outst_tracker;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req, gnt, rvalid;
  logic [63:0] addr;
  logic [3:0]  outst;
  logic [1:0]  gnt_allowed, rvalid_allowed;
  logic [1:0]  err_gnt, err_rv, err_ovf, err_to;
  logic        any_err;
  logic [63:0] resp_addr;

  int checks   = 0;
  int failures = 0;

`ifdef OBI_TRACK_ADDR_EN
  localparam bit ADDR_EN = 1'b1;
`else
  localparam bit ADDR_EN = 1'b0;
`endif

  always #5 clock = ~clock;

  obi_outst_tracker #(
    .NUM_CH(2), .MAX_OUTST(2), .TIMEOUT(4), .AW(32)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .req_i                 (req),
    .gnt_i                 (gnt),
    .rvalid_i              (rvalid),
    .addr_i                (addr),
    .outst_o               (outst),
    .gnt_allowed_o         (gnt_allowed),
    .rvalid_allowed_o      (rvalid_allowed),
    .err_gnt_no_req_o      (err_gnt),
    .err_rvalid_no_outst_o (err_rv),
    .err_overflow_o        (err_ovf),
    .err_timeout_o         (err_to),
    .any_err_o             (any_err),
    .resp_addr_o           (resp_addr)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] r, input logic [1:0] g,
                     input logic [1:0] v, input logic [31:0] a0);
    req    = r;
    gnt    = g;
    rvalid = v;
    addr   = {32'h0, a0};
    @(posedge clock);
    #1;
    req    = '0;
    gnt    = '0;
    rvalid = '0;
    addr   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [63:0] ea(input logic [31:0] a);
    return ADDR_EN ? {32'h0, a} : 64'h0;
  endfunction

  initial begin
    reset  = 1'b1;
    req    = '0;
    gnt    = '0;
    rvalid = '0;
    addr   = '0;
    #3;
    // T1: reset state
    check("rst_outst", outst, 4'h0);
    check("rst_gnt_allowed", gnt_allowed, 2'b11);
    check("rst_rvalid_allowed", rvalid_allowed, 2'b00);
    check("rst_errs", {err_gnt, err_rv, err_ovf, err_to}, 8'h00);
    check("rst_any_err", any_err, 1'b0);
    check("rst_resp_addr", resp_addr, 64'h0);
    @(negedge clock);
    reset = 1'b0;

    // T5a: timeout fires after 4 waiting cycles
    cyc(2'b01, 2'b01, 2'b00, 32'h0);
    repeat (3) cyc(2'b00, 2'b00, 2'b00, 32'h0);
    check("to_not_yet", err_to, 2'b00);
    check("to_outst", outst, 4'h1);
    cyc(2'b00, 2'b00, 2'b00, 32'h0);
    check("to_set", err_to, 2'b01);
    check("to_any_err", any_err, 1'b1);
    do_reset();

    // T5b: rvalid on cycle 3 avoids timeout
    cyc(2'b01, 2'b01, 2'b00, 32'h0);
    repeat (2) cyc(2'b00, 2'b00, 2'b00, 32'h0);
    cyc(2'b00, 2'b00, 2'b01, 32'h0);
    repeat (6) cyc(2'b00, 2'b00, 2'b00, 32'h0);
    check("noto_flag", err_to, 2'b00);
    check("noto_outst", outst, 4'h0);
    check("noto_any_err", any_err, 1'b0);
    do_reset();

    // T2/T6: fill, drain, simultaneous accept+response, address order
    cyc(2'b01, 2'b01, 2'b00, 32'h100);
    cyc(2'b01, 2'b01, 2'b00, 32'h200);
    check("fill_outst", outst, 4'h2);
    check("fill_gnt_allowed", gnt_allowed, 2'b10);
    check("fill_rvalid_allowed", rvalid_allowed, 2'b01);
    check("fill_resp_addr", resp_addr, ea(32'h100));
    rvalid = 2'b01;
    #1;
    check("full_gnt_allowed_rv", gnt_allowed, 2'b11);
    cyc(2'b00, 2'b00, 2'b01, 32'h0);
    check("drain_outst", outst, 4'h1);
    check("drain_resp_addr", resp_addr, ea(32'h200));
    cyc(2'b01, 2'b01, 2'b01, 32'h300);
    check("accrv_outst", outst, 4'h1);
    check("accrv_resp_addr", resp_addr, ea(32'h300));
    check("accrv_any_err", any_err, 1'b0);

    // T4: overflow saturates and is not pushed
    cyc(2'b01, 2'b01, 2'b00, 32'h400);
    check("refill_outst", outst, 4'h2);
    check("refill_no_ovf", err_ovf, 2'b00);
    cyc(2'b01, 2'b01, 2'b00, 32'h500);
    check("ovf_flag", err_ovf, 2'b01);
    check("ovf_outst", outst, 4'h2);
    check("ovf_resp_addr", resp_addr, ea(32'h300));
    cyc(2'b00, 2'b00, 2'b01, 32'h0);
    check("ovf_pop_outst", outst, 4'h1);
    check("ovf_pop_resp_addr", resp_addr, ea(32'h400));

    // T6: asynchronous reset mid-cycle
    #2;
    reset = 1'b1;
    #1;
    check("arst_outst", outst, 4'h0);
    check("arst_resp_addr", resp_addr, 64'h0);
    check("arst_ovf", err_ovf, 2'b00);
    check("arst_any_err", any_err, 1'b0);
    check("arst_rvalid_allowed", rvalid_allowed, 2'b00);
    check("arst_gnt_allowed", gnt_allowed, 2'b11);
    @(negedge clock);
    reset = 1'b0;

    // T3: protocol violations, stickiness, channel independence
    cyc(2'b00, 2'b00, 2'b10, 32'h0);
    check("rvnoo_flag", err_rv, 2'b10);
    check("rvnoo_outst", outst, 4'h0);
    check("rvnoo_any_err", any_err, 1'b1);
    repeat (10) cyc(2'b00, 2'b00, 2'b00, 32'h0);
    check("rvnoo_sticky", err_rv, 2'b10);
    check("rvnoo_any_sticky", any_err, 1'b1);
    cyc(2'b00, 2'b01, 2'b00, 32'h0);
    check("gnr_flag", err_gnt, 2'b01);
    check("gnr_outst", outst, 4'h0);
    cyc(2'b10, 2'b10, 2'b10, 32'h0);
    check("rv0_acc_outst", outst, 4'h4);
    check("rv0_acc_rvalid_allowed", rvalid_allowed, 2'b10);
    check("rv0_acc_ovf", err_ovf, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
